data_memory_v3: RTL and testbench

DATA_MEMORY_V3 -- requirements
Module: data_memory_v3

---
 rtl/data_memory_v3.sv | 188 ++++++++++++++++++
 tb/tb_data_memory_v3.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_v3.sv
// Load/store unit between the pipeline and a word-wide valid/ready data bus:
// decodes access size, lane-aligns stores, and shifts/extends load results.
module data_memory_v3 #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [XLEN-1:0]   i_wr_data,
  input  logic [XLEN-1:0]   i_addr,
  input  logic [2:0]        i_f3,
  input  logic              i_wr_en,
  input  logic              i_rd_en,
  output logic [XLEN-1:0]   o_rd,
  output logic              o_stall,
  output logic              o_ex_ld,
  output logic              o_ex_st,
  output logic              o_ex_bus,
  output logic              o_dm_valid,
  input  logic              i_dm_ready,
  output logic              o_dm_we,
  output logic [XLEN-1:0]   o_dm_addr,
  output logic [XLEN-1:0]   o_dm_wdata,
  output logic [XLEN/8-1:0] o_dm_be,
  input  logic              i_dm_rvalid,
  input  logic [XLEN-1:0]   i_dm_rdata,
  input  logic              i_dm_err
);

  localparam int unsigned NB    = XLEN / 8;
  localparam int unsigned OFF_W = $clog2(NB);
  localparam int unsigned CNT_W = 32;
  localparam bit          IS64  = (XLEN == 64);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [2:0]         f3_q;
  logic [OFF_W-1:0]   off_q;

  logic [OFF_W-1:0]   off;
  logic [1:0]         sz;
  logic               load_req;
  logic               misalign;
  logic               st_legal;
  logic               ld_legal;
  logic               ex_any;
  logic               go;
  logic               timeout_hit;
  logic [NB-1:0]      size_mask;
  logic [XLEN-1:0]    shifted;
  logic [XLEN-1:0]    ext;

  assign off      = i_addr[OFF_W-1:0];
  assign sz       = i_f3[1:0];
  assign load_req = i_rd_en & ~i_wr_en;

  // Natural alignment: the low log2(size) address bits must be zero.
  always_comb begin
    misalign = 1'b0;
    case (sz)
      2'b01:   misalign = off[0];
      2'b10:   misalign = |off[1:0];
      2'b11:   misalign = |off;
      default: misalign = 1'b0;
    endcase
  end

  assign st_legal = (sz != 2'b11) || IS64;

  always_comb begin
    ld_legal = 1'b0;
    case (i_f3)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ld_legal = 1'b1;
      3'b011, 3'b110:                         ld_legal = IS64;
      default:                                ld_legal = 1'b0;
    endcase
  end

  // A store masks the load entirely, so o_ex_ld only looks at pure loads.
  assign o_ex_st = i_wr_en & (misalign | ~st_legal);
  assign o_ex_ld = load_req & (misalign | ~ld_legal);
  assign ex_any  = o_ex_st | o_ex_ld;
  assign go      = (i_wr_en | i_rd_en) & ~ex_any;

  assign o_stall = ((i_wr_en | i_rd_en) | (state == S_REQ) | (state == S_WAIT))
                   & (state != S_DONE) & ~ex_any;

  always_comb begin
    size_mask = NB'(8'h01);
    case (sz)
      2'b00:   size_mask = NB'(8'h01);
      2'b01:   size_mask = NB'(8'h03);
      2'b10:   size_mask = NB'(8'h0F);
      default: size_mask = NB'(8'hFF);
    endcase
  end

  // Saturating compare so a handshake landing on the last cycle still times out in WAIT.
  assign timeout_hit = (TIMEOUT != 0) && (cnt >= CNT_W'(TIMEOUT - 1));

  assign shifted = i_dm_rdata >> {off_q, 3'b000};

  always_comb begin
    ext = '0;
    case (f3_q)
      3'b000:  ext = XLEN'($signed(shifted[7:0]));
      3'b001:  ext = XLEN'($signed(shifted[15:0]));
      3'b010:  ext = XLEN'($signed(shifted[31:0]));
      3'b011:  ext = shifted;
      3'b100:  ext = XLEN'(shifted[7:0]);
      3'b101:  ext = XLEN'(shifted[15:0]);
      3'b110:  ext = XLEN'(shifted[31:0]);
      default: ext = '0;
    endcase
  end

  // Bus transaction sequencer; every bus-facing output is registered here.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      f3_q       <= '0;
      off_q      <= '0;
      o_dm_valid <= 1'b0;
      o_dm_we    <= 1'b0;
      o_dm_addr  <= '0;
      o_dm_wdata <= '0;
      o_dm_be    <= '0;
      o_rd       <= '0;
      o_ex_bus   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          o_ex_bus <= 1'b0;
          if (go) begin
            state      <= S_REQ;
            cnt        <= '0;
            o_dm_valid <= 1'b1;
            o_dm_we    <= i_wr_en;
            o_dm_addr  <= {i_addr[XLEN-1:OFF_W], OFF_W'(0)};
            o_dm_be    <= size_mask << off;
            o_dm_wdata <= i_wr_data << {off, 3'b000};
            f3_q       <= i_f3;
            off_q      <= off;
          end
        end
        S_REQ: begin
          cnt <= cnt + CNT_W'(1);
          if (i_dm_ready) begin
            o_dm_valid <= 1'b0;
            if (i_dm_rvalid) begin
              state    <= S_DONE;
              o_ex_bus <= i_dm_err;
              o_rd     <= o_dm_we ? '0 : ext;
            end else begin
              state <= S_WAIT;
            end
          end else if (timeout_hit) begin
            o_dm_valid <= 1'b0;
            state      <= S_DONE;
            o_ex_bus   <= 1'b1;
            o_rd       <= '0;
          end
        end
        S_WAIT: begin
          cnt <= cnt + CNT_W'(1);
          if (i_dm_rvalid) begin
            state    <= S_DONE;
            o_ex_bus <= i_dm_err;
            o_rd     <= o_dm_we ? '0 : ext;
          end else if (timeout_hit) begin
            state    <= S_DONE;
            o_ex_bus <= 1'b1;
            o_rd     <= '0;
          end
        end
        S_DONE: begin
          state    <= S_IDLE;
          o_ex_bus <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_v3.sv
// Scoreboard bench: drivers queue expected bus requests and responses,
// monitors pop and compare them when the DUTs present handshakes or completions.
module tb_data_memory_v3;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int total = 0;
  int bad   = 0;

  // XLEN=32 instance with a short timeout
  logic [31:0] a_wr_data, a_addr, a_rd, a_dm_addr, a_wdata, a_rdata;
  logic [2:0]  a_f3;
  logic        a_wr_en, a_rd_en, a_stall, a_ex_ld, a_ex_st, a_ex_bus;
  logic        a_valid, a_ready, a_we, a_rvalid, a_err;
  logic [3:0]  a_be;

  data_memory_v3 #(.XLEN(32), .TIMEOUT(4)) u_a (
    .i_clk(clk), .i_rst(rst), .i_wr_data(a_wr_data), .i_addr(a_addr), .i_f3(a_f3),
    .i_wr_en(a_wr_en), .i_rd_en(a_rd_en), .o_rd(a_rd), .o_stall(a_stall),
    .o_ex_ld(a_ex_ld), .o_ex_st(a_ex_st), .o_ex_bus(a_ex_bus), .o_dm_valid(a_valid),
    .i_dm_ready(a_ready), .o_dm_we(a_we), .o_dm_addr(a_dm_addr), .o_dm_wdata(a_wdata),
    .o_dm_be(a_be), .i_dm_rvalid(a_rvalid), .i_dm_rdata(a_rdata), .i_dm_err(a_err)
  );

  // XLEN=64 instance with a zero-wait slave
  logic [63:0] b_wr_data, b_addr, b_rd, b_dm_addr, b_wdata, b_rdata, b_rsp_data;
  logic [2:0]  b_f3;
  logic        b_wr_en, b_rd_en, b_stall, b_ex_ld, b_ex_st, b_ex_bus;
  logic        b_valid, b_ready, b_we, b_rvalid, b_err;
  logic [7:0]  b_be;

  assign b_ready  = b_valid;
  assign b_rvalid = b_valid;
  assign b_rdata  = b_rsp_data;
  assign b_err    = 1'b0;

  data_memory_v3 #(.XLEN(64), .TIMEOUT(255)) u_b (
    .i_clk(clk), .i_rst(rst), .i_wr_data(b_wr_data), .i_addr(b_addr), .i_f3(b_f3),
    .i_wr_en(b_wr_en), .i_rd_en(b_rd_en), .o_rd(b_rd), .o_stall(b_stall),
    .o_ex_ld(b_ex_ld), .o_ex_st(b_ex_st), .o_ex_bus(b_ex_bus), .o_dm_valid(b_valid),
    .i_dm_ready(b_ready), .o_dm_we(b_we), .o_dm_addr(b_dm_addr), .o_dm_wdata(b_wdata),
    .o_dm_be(b_be), .i_dm_rvalid(b_rvalid), .i_dm_rdata(b_rdata), .i_dm_err(b_err)
  );

  typedef struct packed {
    logic        we;
    logic [63:0] addr;
    logic [7:0]  be;
    logic [63:0] wdata;
  } req_t;

  typedef struct packed {
    logic        chk_rd;
    logic [63:0] rd;
    logic        bus;
  } rsp_t;

  req_t a_req_q[$];
  rsp_t a_rsp_q[$];
  req_t b_req_q[$];
  rsp_t b_rsp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Slave model for instance A: ready after a_ready_lat valid cycles, response a_rsp_lat later.
  int          a_ready_lat = -1;
  int          a_rsp_lat   = 0;
  logic [31:0] a_rsp_data  = '0;
  logic        a_rsp_err   = 1'b0;
  bit          a_pend      = 1'b0;
  int          a_pend_cnt  = 0;
  int          a_wait_cnt  = 0;

  initial begin
    a_ready = 1'b0; a_rvalid = 1'b0; a_rdata = '0; a_err = 1'b0;
    forever begin
      @(posedge clk); #1;
      a_ready = 1'b0; a_rvalid = 1'b0; a_rdata = '0; a_err = 1'b0;
      if (a_pend) begin
        if (a_pend_cnt == 0) begin
          a_rvalid = 1'b1; a_rdata = a_rsp_data; a_err = a_rsp_err; a_pend = 1'b0;
        end else begin
          a_pend_cnt--;
        end
      end else if (a_valid && a_ready_lat >= 0) begin
        if (a_wait_cnt == a_ready_lat) begin
          a_ready = 1'b1; a_wait_cnt = 0;
          if (a_rsp_lat == 0) begin
            a_rvalid = 1'b1; a_rdata = a_rsp_data; a_err = a_rsp_err;
          end else begin
            a_pend = 1'b1; a_pend_cnt = a_rsp_lat - 1;
          end
        end else begin
          a_wait_cnt++;
        end
      end
    end
  end

  // Monitor A
  initial begin : mon_a
    req_t r;
    rsp_t s;
    forever begin
      @(negedge clk);
      if (a_valid && a_ready) begin
        if (a_req_q.size() == 0) begin
          total++; bad++;
          $display("FAIL a_unexpected_req: got addr %0h want none", a_dm_addr);
        end else begin
          r = a_req_q.pop_front();
          chk("a_dm_we", 64'(a_we), 64'(r.we));
          chk("a_dm_addr", 64'(a_dm_addr), r.addr);
          chk("a_dm_be", 64'(a_be), 64'(r.be));
          chk("a_dm_wdata", 64'(a_wdata), r.wdata);
        end
      end
      if ((a_wr_en || a_rd_en) && !a_stall && !a_ex_ld && !a_ex_st && !rst) begin
        if (a_rsp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL a_unexpected_done: got rd %0h want none", a_rd);
        end else begin
          s = a_rsp_q.pop_front();
          if (s.chk_rd) chk("a_rd", 64'(a_rd), s.rd);
          chk("a_ex_bus", 64'(a_ex_bus), 64'(s.bus));
        end
      end
    end
  end

  // Monitor B
  initial begin : mon_b
    req_t r;
    rsp_t s;
    forever begin
      @(negedge clk);
      if (b_valid && b_ready) begin
        if (b_req_q.size() == 0) begin
          total++; bad++;
          $display("FAIL b_unexpected_req: got addr %0h want none", b_dm_addr);
        end else begin
          r = b_req_q.pop_front();
          chk("b_dm_we", 64'(b_we), 64'(r.we));
          chk("b_dm_addr", b_dm_addr, r.addr);
          chk("b_dm_be", 64'(b_be), 64'(r.be));
          chk("b_dm_wdata", b_wdata, r.wdata);
        end
      end
      if ((b_wr_en || b_rd_en) && !b_stall && !b_ex_ld && !b_ex_st && !rst) begin
        if (b_rsp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL b_unexpected_done: got rd %0h want none", b_rd);
        end else begin
          s = b_rsp_q.pop_front();
          if (s.chk_rd) chk("b_rd", b_rd, s.rd);
          chk("b_ex_bus", 64'(b_ex_bus), 64'(s.bus));
        end
      end
    end
  end

  // Issue one request on A and hold it until the stall releases.
  task automatic access_a(input bit wr, input bit rd, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int rlat, input int slat,
                          input logic [31:0] rdata, input logic rerr,
                          input logic [31:0] e_addr, input logic [3:0] e_be,
                          input logic [31:0] e_wdata, input logic [31:0] e_rd,
                          input logic e_bus, input bit e_chk_rd,
                          input int e_lat, input int e_nv);
    int n, nv;
    req_t q;
    rsp_t s;
    a_ready_lat = rlat; a_rsp_lat = slat; a_rsp_data = rdata; a_rsp_err = rerr;
    if (rlat >= 0) begin
      q.we = wr; q.addr = 64'(e_addr); q.be = 8'(e_be); q.wdata = 64'(e_wdata);
      a_req_q.push_back(q);
    end
    s.chk_rd = e_chk_rd; s.rd = 64'(e_rd); s.bus = e_bus;
    a_rsp_q.push_back(s);
    a_wr_en = wr; a_rd_en = rd; a_f3 = f3; a_addr = addr; a_wr_data = wdata;
    @(negedge clk);
    chk("a_ex_ld_legal", 64'(a_ex_ld), 64'd0);
    chk("a_ex_st_legal", 64'(a_ex_st), 64'd0);
    n = 1; nv = 0;
    while (a_stall && n < 40) begin
      @(negedge clk);
      n++;
      if (a_valid) nv++;
    end
    if (a_stall) begin
      total++; bad++;
      $display("FAIL a_done_wait: got stall 1 after %0d cycles want 0", n);
    end
    chk("a_latency", 64'(n), 64'(e_lat));
    chk("a_valid_cycles", 64'(nv), 64'(e_nv));
    @(posedge clk); #1;
    a_wr_en = 1'b0; a_rd_en = 1'b0;
  endtask

  task automatic ex_a(input bit wr, input bit rd, input logic [2:0] f3,
                      input logic [31:0] addr, input logic e_ld, input logic e_st);
    a_wr_en = wr; a_rd_en = rd; a_f3 = f3; a_addr = addr; a_wr_data = 32'h5555_5555;
    repeat (2) begin
      @(negedge clk);
      chk("a_ex_ld", 64'(a_ex_ld), 64'(e_ld));
      chk("a_ex_st", 64'(a_ex_st), 64'(e_st));
      chk("a_ex_stall", 64'(a_stall), 64'd0);
      chk("a_ex_valid", 64'(a_valid), 64'd0);
    end
    @(posedge clk); #1;
    a_wr_en = 1'b0; a_rd_en = 1'b0;
  endtask

  task automatic access_b(input bit wr, input bit rd, input logic [2:0] f3,
                          input logic [63:0] addr, input logic [63:0] wdata,
                          input logic [63:0] rdata, input logic [63:0] e_addr,
                          input logic [7:0] e_be, input logic [63:0] e_wdata,
                          input logic [63:0] e_rd);
    int n;
    req_t q;
    rsp_t s;
    q.we = wr; q.addr = e_addr; q.be = e_be; q.wdata = e_wdata;
    b_req_q.push_back(q);
    s.chk_rd = 1'b1; s.rd = e_rd; s.bus = 1'b0;
    b_rsp_q.push_back(s);
    b_rsp_data = rdata;
    b_wr_en = wr; b_rd_en = rd; b_f3 = f3; b_addr = addr; b_wr_data = wdata;
    @(negedge clk);
    chk("b_ex_ld_legal", 64'(b_ex_ld), 64'd0);
    chk("b_ex_st_legal", 64'(b_ex_st), 64'd0);
    n = 1;
    while (b_stall && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (b_stall) begin
      total++; bad++;
      $display("FAIL b_done_wait: got stall 1 after %0d cycles want 0", n);
    end
    chk("b_latency", 64'(n), 64'd3);
    @(posedge clk); #1;
    b_wr_en = 1'b0; b_rd_en = 1'b0;
  endtask

  task automatic ex_b(input logic [2:0] f3, input logic [63:0] addr);
    b_wr_en = 1'b0; b_rd_en = 1'b1; b_f3 = f3; b_addr = addr; b_wr_data = '0;
    @(negedge clk);
    chk("b_ex_ld", 64'(b_ex_ld), 64'd1);
    chk("b_ex_stall", 64'(b_stall), 64'd0);
    chk("b_ex_valid", 64'(b_valid), 64'd0);
    @(posedge clk); #1;
    b_rd_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    a_wr_en = 1'b0; a_rd_en = 1'b0; a_f3 = '0; a_addr = '0; a_wr_data = '0;
    b_wr_en = 1'b0; b_rd_en = 1'b0; b_f3 = '0; b_addr = '0; b_wr_data = '0;
    b_rsp_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_a_valid", 64'(a_valid), 64'd0);
    chk("rst_a_we", 64'(a_we), 64'd0);
    chk("rst_a_be", 64'(a_be), 64'd0);
    chk("rst_a_addr", 64'(a_dm_addr), 64'd0);
    chk("rst_a_wdata", 64'(a_wdata), 64'd0);
    chk("rst_a_rd", 64'(a_rd), 64'd0);
    chk("rst_a_ex_bus", 64'(a_ex_bus), 64'd0);
    chk("rst_a_stall", 64'(a_stall), 64'd0);
    chk("rst_b_valid", 64'(b_valid), 64'd0);
    chk("rst_b_rd", b_rd, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    //       wr rd f3      addr          wdata          rl sl rdata          err  e_addr        be      e_wdata        e_rd          bus chk lat nv
    access_a(1, 0, 3'b000, 32'h0000_1003, 32'h0000_00AB, 0, 0, 32'h0,         0, 32'h0000_1000, 4'b1000, 32'hAB00_0000, 32'h0,         0, 1, 3, 1);
    access_a(0, 1, 3'b000, 32'h0000_2002, 32'h0,         1, 1, 32'h0080_0000, 0, 32'h0000_2000, 4'b0100, 32'h0,         32'hFFFF_FF80, 0, 1, 5, 2);
    access_a(0, 1, 3'b100, 32'h0000_2002, 32'h0,         0, 1, 32'h0080_0000, 0, 32'h0000_2000, 4'b0100, 32'h0,         32'h0000_0080, 0, 1, 4, 1);
    access_a(0, 1, 3'b001, 32'h0000_2002, 32'h0,         0, 0, 32'h8001_0000, 0, 32'h0000_2000, 4'b1100, 32'h0,         32'hFFFF_8001, 0, 1, 3, 1);
    access_a(0, 1, 3'b101, 32'h0000_2000, 32'h0,         0, 0, 32'h1234_F00D, 0, 32'h0000_2000, 4'b0011, 32'h0,         32'h0000_F00D, 0, 1, 3, 1);
    access_a(0, 1, 3'b010, 32'h0000_3000, 32'h0,         2, 0, 32'hDEAD_BEEF, 1, 32'h0000_3000, 4'b1111, 32'h0,         32'hDEAD_BEEF, 1, 1, 5, 3);
    access_a(1, 0, 3'b001, 32'h0000_4002, 32'h0000_BEEF, 0, 0, 32'h0,         0, 32'h0000_4000, 4'b1100, 32'hBEEF_0000, 32'h0,         0, 1, 3, 1);
    // store wins over a load that would be illegal on its own
    access_a(1, 1, 3'b110, 32'h0000_0020, 32'h1122_3344, 0, 0, 32'h0,         0, 32'h0000_0020, 4'b1111, 32'h1122_3344, 32'h0,         0, 1, 3, 1);
    // slave never ready: four valid cycles then a bus error
    access_a(0, 1, 3'b010, 32'h0000_6000, 32'h0,        -1, 0, 32'h0,         0, 32'h0,         4'b0000, 32'h0,         32'h0,         1, 0, 6, 4);
    @(negedge clk);
    chk("a_timeout_idle_ex_bus", 64'(a_ex_bus), 64'd0);
    chk("a_timeout_idle_valid", 64'(a_valid), 64'd0);
    @(posedge clk); #1;

    ex_a(0, 1, 3'b010, 32'h0000_3002, 1, 0);
    ex_a(1, 0, 3'b001, 32'h0000_3001, 0, 1);
    ex_a(0, 1, 3'b011, 32'h0000_0000, 1, 0);
    ex_a(0, 1, 3'b110, 32'h0000_0000, 1, 0);
    ex_a(0, 1, 3'b111, 32'h0000_0000, 1, 0);
    ex_a(1, 0, 3'b011, 32'h0000_0000, 0, 1);

    // reset while waiting for a response that arrives one cycle later
    a_ready_lat = 0; a_rsp_lat = 2; a_rsp_data = 32'hFFFF_FFFF; a_rsp_err = 1'b1;
    a_req_q.push_back('{we: 1'b0, addr: 64'h5000, be: 8'h0F, wdata: 64'h0});
    a_rd_en = 1'b1; a_f3 = 3'b010; a_addr = 32'h0000_5000; a_wr_data = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; a_rd_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rstw_valid", 64'(a_valid), 64'd0);
    chk("rstw_stall", 64'(a_stall), 64'd0);
    chk("rstw_rd", 64'(a_rd), 64'd0);
    chk("rstw_be", 64'(a_be), 64'd0);
    chk("rstw_addr", 64'(a_dm_addr), 64'd0);
    chk("rstw_ex_bus", 64'(a_ex_bus), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstw_late_ex_bus", 64'(a_ex_bus), 64'd0);
    chk("rstw_late_rd", 64'(a_rd), 64'd0);
    chk("rstw_late_valid", 64'(a_valid), 64'd0);
    @(posedge clk); #1;

    //       wr rd f3      addr                   wdata                  rdata                  e_addr                 be     e_wdata                e_rd
    access_b(0, 1, 3'b110, 64'h0000_0000_0000_4004, 64'h0,                 64'h8000_0000_0000_0000, 64'h0000_0000_0000_4000, 8'hF0, 64'h0,                 64'h0000_0000_8000_0000);
    access_b(0, 1, 3'b010, 64'h0000_0000_0000_4004, 64'h0,                 64'h8000_0000_0000_0000, 64'h0000_0000_0000_4000, 8'hF0, 64'h0,                 64'hFFFF_FFFF_8000_0000);
    access_b(1, 0, 3'b011, 64'h0000_0000_0000_4008, 64'h0123_4567_89AB_CDEF, 64'h0,                 64'h0000_0000_0000_4008, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'h0);
    access_b(0, 1, 3'b011, 64'h0000_0000_0000_4000, 64'h0,                 64'hCAFE_F00D_1234_5678, 64'h0000_0000_0000_4000, 8'hFF, 64'h0,                 64'hCAFE_F00D_1234_5678);
    access_b(1, 0, 3'b000, 64'h0000_0000_0000_4005, 64'h0000_0000_0000_005A, 64'h0,                 64'h0000_0000_0000_4000, 8'h20, 64'h0000_5A00_0000_0000, 64'h0);
    ex_b(3'b011, 64'h0000_0000_0000_4004);
    ex_b(3'b111, 64'h0000_0000_0000_4000);

    repeat (2) @(posedge clk);
    chk("a_req_q_empty", 64'(a_req_q.size()), 64'd0);
    chk("a_rsp_q_empty", 64'(a_rsp_q.size()), 64'd0);
    chk("b_req_q_empty", 64'(b_req_q.size()), 64'd0);
    chk("b_rsp_q_empty", 64'(b_rsp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000 want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
